vec_imm_stream_buff: RTL and testbench
======================================

# vec_imm_stream_buff

Parametrised successor to the single-lane immediate vector buffer. It accepts a vector immediate as a length followed by a stream of multi-lane data beats under a valid/ready handshake, and assembles it into an N-element register array. The array and length drive the shared vector operand bus through tri-state outputs. Added over the previous generation: synchronous reset, LANES elements per beat, broadcast fill mode, length-range error, and clean restart while a load is in progress.

## Interface
- BITS, 8, element width and length-word width
- N, 64, vector capacity in elements (1 ≤ N ≤ 2^BITS−1)
- LANES, 4, elements per input beat (1 ≤ LANES ≤ N)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin new load; samples start_len and mode
- start_len  in  BITS  element count of the new vector
- mode  in  1  0 = stream, 1 = broadcast (lane 0 replicated)
- in_data  in  BITS×LANES  packed beat; lane k = in_data[k*BITS +: BITS]
- in_valid  in  1  beat present
- in_ready  out  1  buffer accepts beat this cycle
- en  in  1  drive out/out_len onto the bus, else high-Z
- out  out  BITS × [N]  element array (tri-state)
- out_len  out  BITS  captured length (tri-state)
- busy  out  1  load in progress
- done  out  1  load complete, sticky until next start/rst
- err  out  1  start_len > N on the last start, sticky until next start/rst

## Operation
- States: IDLE, LOAD, DONE. Reset state IDLE.
- start in any state (rst has priority) does the following:
  - Zeroes all N elements, clears done/err, sets index = 0.
  - If start_len > N: go to DONE, err = 1, done = 1, len_q = 0.
  - Else if start_len == 0: go to DONE, done = 1, len_q = 0.
  - Else: go to LOAD, len_q = start_len, mode_q = mode.
- in_ready = (state == LOAD) && !start. It is combinational and never depends on in_valid.
- Accepted beat = in_valid && in_ready.
- Stream mode, on an accepted beat:
  - Lane k writes element index+k only when index+k < len_q.
  - index += LANES.
  - If index+LANES ≥ len_q: go to DONE, done = 1.
- Broadcast mode: the first accepted beat writes lane 0 to elements 0..len_q−1 and goes to DONE.
- Lanes beyond len_q in the final beat are discarded. Elements ≥ len_q stay 0.
- busy = (state == LOAD).
- DONE holds until the next start. Beats offered in IDLE or DONE are not accepted.
- index width is $clog2(N+LANES)+1, so index+LANES never wraps.
- out_len = len_q when en, else 'z. out[i] = elem[i] when en, else 'z. en has no effect on internal state.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, len_q 0, all elements 0, index 0. in_ready is 0 during and after rst.
- A start sampled at edge t puts the new state into effect from cycle t+1. in_ready can rise in cycle t+1.
- Stream load of L elements with in_valid held high: ceil(L/LANES) beats. done rises the cycle after the last accepted beat.
- Broadcast load: done rises the cycle after the single accepted beat.
- start_len == 0 or > N: done (and err if applicable) is high in cycle t+1.
- start asserted while in LOAD: the in-flight beat in that cycle is not accepted, and the prior partial contents are zeroed. A restart mid-load leaves no residue.
- rst together with start: rst wins.
- Element and length writes are visible on out/out_len (when en) the cycle after the accepting edge.

## Structure
- Package vec_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, DONE} imm_state_t
  - typedef enum logic {MODE_STREAM, MODE_BCAST} imm_mode_t
  - shared localparams for bus width defaults
- Sub-module vec_tri_drv #(BITS, N): the en-gated tri-state driver for the array and the length. It is reused by the other operand sources on the bus.
- Everything else is one always_ff for state, index and array, plus combinational in_ready/busy.

## Test plan
- Reset, then en = 1: out_len = 0, all out = 0, busy/done/err = 0, in_ready = 0. With en = 0, all out/out_len = 'z.
- N=64, LANES=4, stream, start_len = 10, beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12}:
  - Exactly 3 beats are accepted, and done rises the cycle after the third.
  - out[0..9] = 1..10, out[10..63] = 0, out_len = 10.
- Same load with in_valid toggling 1,0,1,0,1: in_ready stays 1 throughout, the final contents match the previous case, and done is 2 cycles later.
- Broadcast, start_len = 64, beat lane0 = 0xA5: all 64 elements = 0xA5, done after 1 beat, a second offered beat is not accepted.
- start_len = 65: err = 1 and done = 1 next cycle, out_len = 0, in_ready never rises. Then start_len = 0: err clears, done = 1, out_len = 0.
- Stream start_len = 8, accept 1 beat {7,7,7,7}, then start (start_len = 3) with in_valid high in the same cycle:
  - That beat is not accepted, and out[0..3] = 0.
  - The next beat {1,2,3,4} gives out[0..2] = 1,2,3, out[3] = 0, out_len = 3.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and bus-width defaults for the vector operand sources.
package vec_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} imm_state_t;
    typedef enum logic {MODE_STREAM, MODE_BCAST} imm_mode_t;

    localparam int unsigned BITS_DEF  = 8;
    localparam int unsigned N_DEF     = 64;
    localparam int unsigned LANES_DEF = 4;

endpackage

// File: rtl/vec_tri_drv.sv
// Enable-gated tri-state driver for a vector operand array and its length.
module vec_tri_drv #(
    parameter int unsigned BITS = 8,
    parameter int unsigned N    = 64
) (
    input  logic                     en,
    input  logic [N-1:0][BITS-1:0]   elem,
    input  logic [BITS-1:0]          len,
    output logic [N-1:0][BITS-1:0]   out,
    output logic [BITS-1:0]          out_len
);

    assign out     = en ? elem : 'z;
    assign out_len = en ? len  : 'z;

endmodule

// File: rtl/vec_imm_stream_buff.sv
// Immediate vector buffer: length + multi-lane beat stream assembled into an
// N-element array, driven onto the shared operand bus through vec_tri_drv.
module vec_imm_stream_buff
    import vec_pkg::*;
#(
    parameter int unsigned BITS  = BITS_DEF,
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BITS-1:0]          start_len,
    input  logic                     mode,
    input  logic [BITS*LANES-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     en,
    output logic [N-1:0][BITS-1:0]   out,
    output logic [BITS-1:0]          out_len,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned IDX_W = $clog2(N + LANES) + 1;
    // Compare width wide enough for index, element number and length alike.
    localparam int unsigned CW    = IDX_W + BITS;

    imm_state_t               state_q, state_d;
    imm_mode_t                mode_q;
    logic [IDX_W-1:0]         idx_q;
    logic [BITS-1:0]          len_q;
    logic [N-1:0][BITS-1:0]   elem_q;

    logic accept;
    logic too_big;
    logic len_zero;
    logic last_beat;

    assign in_ready  = (state_q == LOAD) && !start;
    assign accept    = in_valid && in_ready;
    assign too_big   = {1'b0, start_len} > (BITS+1)'(N);
    assign len_zero  = (start_len == '0);
    assign last_beat = (mode_q == MODE_BCAST)
                    || (CW'(idx_q) + CW'(LANES) >= CW'(len_q));

    // Next-state decode; a start overrides everything else.
    always_comb begin
        state_d = state_q;
        if (start) begin
            if (too_big || len_zero) state_d = DONE;
            else                     state_d = LOAD;
        end else if (accept && last_beat) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_STREAM;
            idx_q   <= '0;
            len_q   <= '0;
            elem_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == LOAD);
            done    <= (state_d == DONE);
            if (start) begin
                elem_q <= '0;
                idx_q  <= '0;
                err    <= too_big;
                len_q  <= (too_big || len_zero) ? '0 : start_len;
                mode_q <= imm_mode_t'(mode);
            end else if (accept) begin
                idx_q <= idx_q + IDX_W'(LANES);
                // Only elements below len_q are ever written; the rest stay zero.
                for (int unsigned i = 0; i < N; i++) begin
                    if (CW'(i) < CW'(len_q)) begin
                        if (mode_q == MODE_BCAST) begin
                            elem_q[i] <= in_data[BITS-1:0];
                        end else begin
                            for (int unsigned k = 0; k < LANES; k++) begin
                                if (CW'(idx_q) + CW'(k) == CW'(i))
                                    elem_q[i] <= in_data[k*BITS +: BITS];
                            end
                        end
                    end
                end
            end
        end
    end

    vec_tri_drv #(
        .BITS (BITS),
        .N    (N)
    ) u_tri_drv (
        .en      (en),
        .elem    (elem_q),
        .len     (len_q),
        .out     (out),
        .out_len (out_len)
    );

endmodule

// File: tb/tb_vec_imm_stream_buff.sv
// Directed bench for vec_imm_stream_buff (BITS=8, N=64, LANES=4).
module tb_vec_imm_stream_buff;

    localparam int unsigned BITS  = 8;
    localparam int unsigned N     = 64;
    localparam int unsigned LANES = 4;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [BITS-1:0]        start_len;
    logic                   mode;
    logic [BITS*LANES-1:0]  in_data;
    logic                   in_valid;
    logic                   en;
    wire                    in_ready;
    wire [N-1:0][BITS-1:0]  out;
    wire [BITS-1:0]         out_len;
    wire                    busy;
    wire                    done;
    wire                    err;

    int tests;
    int fails;

    vec_imm_stream_buff #(.BITS(BITS), .N(N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_len (start_len),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .out       (out),
        .out_len   (out_len),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  slen;
        logic        mode;
        logic [31:0] data;
        logic        valid;
        logic        rdy;
        logic        busy;
        logic        done;
        logic        err;
        logic [7:0]  len;
        int          pidx;
        logic [7:0]  pval;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] l, input logic m,
                         input logic [31:0] d, input logic v);
        start     = s;
        start_len = l;
        mode      = m;
        in_data   = d;
        in_valid  = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int last_acc;
        int done_cyc;
        int cyc;
        logic [31:0] beats[3];
        logic all_ok;

        tests = 0;
        fails = 0;
        en    = 1'b1;
        rst   = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
        #1;

        // Reset state.
        tick(); tick(); tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_len", 32'(out_len), 32'd0);
        all_ok = 1'b1;
        for (int i = 0; i < int'(N); i++) if (out[i] !== 8'd0) all_ok = 1'b0;
        chk("rst_elems_zero", 32'(all_ok), 32'd1);
        rst = 1'b0;

        // Stream L=10 with in_valid held high.
        beats[0] = 32'h04030201;
        beats[1] = 32'h08070605;
        beats[2] = 32'h0C0B0A09;
        drive(1'b1, 8'd10, 1'b0, 32'h0, 1'b0);
        tick();
        start    = 1'b0;
        acc      = 0;
        last_acc = -1;
        done_cyc = -1;
        cyc      = 0;
        while (cyc < 20 && done_cyc < 0) begin
            in_data  = beats[(acc < 3) ? acc : 2];
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                acc++;
                last_acc = cyc;
            end
            tick();
            cyc++;
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        in_valid = 1'b0;
        chk("strm_beats", 32'(acc), 32'd3);
        chk("strm_done_lat", 32'(done_cyc), 32'(last_acc + 1));
        chk("strm_len", 32'(out_len), 32'd10);
        all_ok = 1'b1;
        for (int i = 0; i < int'(N); i++)
            if (out[i] !== ((i < 10) ? 8'(i + 1) : 8'd0)) all_ok = 1'b0;
        chk("strm_elems", 32'(all_ok), 32'd1);
        en = 1'b0;
        #1;
        chk("bus_release_len", 32'(out_len !== 8'd10), 32'd1);
        chk("bus_release_elem", 32'(out[0] !== 8'd1), 32'd1);
        en = 1'b1;

        // Table: toggling valid, range error, zero length, broadcast.
        tv[0]  = '{1'b1, 8'd10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10, 0,  8'd0};
        tv[1]  = '{1'b0, 8'd0,  1'b0, 32'h04030201, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 0,  8'd1};
        tv[2]  = '{1'b0, 8'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 3,  8'd4};
        tv[3]  = '{1'b0, 8'd0,  1'b0, 32'h08070605, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 7,  8'd8};
        tv[4]  = '{1'b0, 8'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd10, 8,  8'd0};
        tv[5]  = '{1'b0, 8'd0,  1'b0, 32'h0C0B0A09, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10, 9,  8'd10};
        tv[6]  = '{1'b0, 8'd0,  1'b0, 32'h55555555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 10, 8'd0};
        tv[7]  = '{1'b1, 8'd65, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,  0,  8'd0};
        tv[8]  = '{1'b0, 8'd0,  1'b0, 32'h01010101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,  5,  8'd0};
        tv[9]  = '{1'b1, 8'd0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  0,  8'd0};
        tv[10] = '{1'b1, 8'd64, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd64, 0,  8'd0};
        tv[11] = '{1'b0, 8'd0,  1'b0, 32'h332211A5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd64, 63, 8'hA5};
        tv[12] = '{1'b0, 8'd0,  1'b0, 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd64, 0,  8'hA5};
        for (int s = 0; s < 13; s++) begin
            drive(tv[s].start, tv[s].slen, tv[s].mode, tv[s].data, tv[s].valid);
            #1;
            chk($sformatf("tv%0d_ready", s), 32'(in_ready), 32'(tv[s].rdy));
            tick();
            chk($sformatf("tv%0d_busy", s), 32'(busy), 32'(tv[s].busy));
            chk($sformatf("tv%0d_done", s), 32'(done), 32'(tv[s].done));
            chk($sformatf("tv%0d_err", s), 32'(err), 32'(tv[s].err));
            chk($sformatf("tv%0d_len", s), 32'(out_len), 32'(tv[s].len));
            chk($sformatf("tv%0d_elem", s), 32'(out[tv[s].pidx]), 32'(tv[s].pval));
        end
        all_ok = 1'b1;
        for (int i = 0; i < int'(N); i++) if (out[i] !== 8'hA5) all_ok = 1'b0;
        chk("bcast_all_a5", 32'(all_ok), 32'd1);

        // Restart mid-load: no residue, in-flight beat dropped.
        drive(1'b1, 8'd8, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 1'b0, 32'h07070707, 1'b1);
        tick();
        chk("rs_first_beat", 32'(out[2]), 32'h07);
        drive(1'b1, 8'd3, 1'b0, 32'h07070707, 1'b1);
        #1;
        chk("rs_ready_low", 32'(in_ready), 32'd0);
        tick();
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) if (out[i] !== 8'd0) all_ok = 1'b0;
        chk("rs_zeroed", 32'(all_ok), 32'd1);
        chk("rs_len", 32'(out_len), 32'd3);
        chk("rs_busy", 32'(busy), 32'd1);
        drive(1'b0, 8'd0, 1'b0, 32'h04030201, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("rs_e0", 32'(out[0]), 32'd1);
        chk("rs_e1", 32'(out[1]), 32'd2);
        chk("rs_e2", 32'(out[2]), 32'd3);
        chk("rs_e3", 32'(out[3]), 32'd0);
        chk("rs_done", 32'(done), 32'd1);

        // Reset beats a simultaneous start.
        rst = 1'b1;
        drive(1'b1, 8'd5, 1'b0, 32'h0, 1'b0);
        tick();
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_len", 32'(out_len), 32'd0);
        chk("rst_start_done", 32'(done), 32'd0);
        chk("rst_start_elem", 32'(out[0]), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
